// File: rtl/arith_unit_serial.sv
// arith_unit_serial: digit-serial adder/subtractor.
// An accepted operand set is processed DIGIT bits per cycle, LSB chunk first.
// The result and its flags are held until the consumer takes them.
module arith_unit_serial #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             err
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] op2;
    logic             illegal_reg;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_chunk;
    logic             accept;
    logic [DIGIT-1:0] a_chunk;
    logic [DIGIT-1:0] b_chunk;
    logic [DIGIT:0]   chunk_sum;
    logic             msb_carry_in;
    int               base;

    assign accept     = in_valid && in_ready;
    assign last_chunk = (cnt == CW'(N - 1));

    // Second operand is pre-shaped at capture so BUSY only ever adds a_reg + b_reg + carry
    always_comb begin
        op2 = '0;
        case (sel[1:0])
            2'b00:   op2 = '0;
            2'b01:   op2 = b;
            2'b10:   op2 = ~b;
            default: op2 = '1;
        endcase
    end

    // One DIGIT-wide slice of the ripple add; the carry into the top bit is recovered
    // from the sum bit so signed overflow can be formed on the last chunk
    always_comb begin
        base         = int'(cnt) * DIGIT;
        a_chunk      = a_reg[base +: DIGIT];
        b_chunk      = b_reg[base +: DIGIT];
        chunk_sum    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{DIGIT{1'b0}}, carry};
        msb_carry_in = chunk_sum[DIGIT-1] ^ a_chunk[DIGIT-1] ^ b_chunk[DIGIT-1];
        res_next     = res_reg;
        res_next[base +: DIGIT] = chunk_sum[DIGIT-1:0];
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; in_ready drops while reset is held
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_chunk) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, chunk sequencing and final result registration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg       <= '0;
            b_reg       <= '0;
            res_reg     <= '0;
            illegal_reg <= 1'b0;
            carry       <= 1'b0;
            cnt         <= '0;
            out         <= '0;
            cout        <= 1'b0;
            ovf         <= 1'b0;
            zero        <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg       <= a;
                        b_reg       <= op2;
                        carry       <= cin;
                        illegal_reg <= sel[2];
                        cnt         <= '0;
                        res_reg     <= '0;
                    end
                end
                BUSY: begin
                    carry   <= chunk_sum[DIGIT];
                    res_reg <= res_next;
                    cnt     <= cnt + CW'(1);
                    if (last_chunk) begin
                        out  <= illegal_reg ? '0 : res_next;
                        cout <= !illegal_reg && chunk_sum[DIGIT];
                        ovf  <= !illegal_reg && (msb_carry_in ^ chunk_sum[DIGIT]);
                        zero <= illegal_reg || (res_next == '0);
                        err  <= illegal_reg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arith_unit_serial.sv
// tb_arith_unit_serial: directed and randomized checks of arith_unit_serial
// against a whole-word arithmetic reference model.
module tb_arith_unit_serial;

    localparam int WIDTH = 32;
    localparam int DIGIT = 8;
    localparam int N     = WIDTH / DIGIT;

    typedef struct packed {
        logic [31:0] out;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        err;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [2:0]  sel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        err;

    int n_checks = 0;
    int n_passed = 0;

    arith_unit_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sel(sel),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .cout(cout), .ovf(ovf), .zero(zero), .err(err)
    );

    // Free-running clock, 10 ns period
    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic res_t mk(input logic [31:0] o, input logic c, input logic v,
                                input logic z, input logic e);
        res_t r;
        r.out = o; r.cout = c; r.ovf = v; r.zero = z; r.err = e;
        return r;
    endfunction

    // Whole-word reference: 33-bit sum, overflow from operand/result signs
    function automatic res_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic mcin, input logic [2:0] msel);
        res_t        r;
        logic [31:0] op2;
        logic [32:0] full;
        if (msel[2]) return mk(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        case (msel[1:0])
            2'd0:    op2 = 32'h0;
            2'd1:    op2 = mb;
            2'd2:    op2 = ~mb;
            default: op2 = 32'hFFFF_FFFF;
        endcase
        full   = {1'b0, ma} + {1'b0, op2} + {32'h0, mcin};
        r.out  = full[31:0];
        r.cout = full[32];
        r.ovf  = (ma[31] == op2[31]) && (r.out[31] != ma[31]);
        r.zero = (r.out == 32'h0);
        r.err  = 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [4];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'hFFFF_FFFF;
        corners[2] = 32'h8000_0000;
        corners[3] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkResult(input string tag, input res_t exp);
        checkOutput({tag, ".out"},  out, exp.out);
        checkOutput({tag, ".cout"}, 32'(cout), 32'(exp.cout));
        checkOutput({tag, ".ovf"},  32'(ovf),  32'(exp.ovf));
        checkOutput({tag, ".zero"}, 32'(zero), 32'(exp.zero));
        checkOutput({tag, ".err"},  32'(err),  32'(exp.err));
    endtask

    task automatic scramble_inputs();
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom);
        sel = 3'($urandom);
    endtask

    // One full transaction: accept, latency, result, DONE hold with in_valid high, handshake
    task automatic applyStimulus(input logic [31:0] ia, input logic [31:0] ib, input logic icin,
                                 input logic [2:0] isel, input int hold, input res_t exp,
                                 input bit drop_rst);
        int lat;
        @(negedge clk);
        if (drop_rst) rst = 1'b0;
        a = ia; b = ib; cin = icin; sel = isel;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1 checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        scramble_inputs();
        checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            scramble_inputs();
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'(N));
        checkResult("result", exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            scramble_inputs();
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
            checkResult("hold", exp);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("post_valid", 32'(out_valid), 32'd0);
        checkOutput("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Mid-cycle reset while a result is on display
    task automatic rst_in_done();
        @(negedge clk);
        a = 32'h8000_0000; b = 32'h1; cin = 1'b1; sel = 3'b010;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (N) @(posedge clk);
        #3;
        checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
        checkOutput("pre_rst_out", out, 32'h7FFF_FFFF);
        rst = 1'b1;
        #1;
        checkResult("async_rst", mk(32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("async_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 checkOutput("rel_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Reset in the second BUSY cycle; the aborted result must never appear
    task automatic rst_in_busy();
        int seen;
        @(negedge clk);
        a = 32'h0000_00FF; b = 32'h1; cin = 1'b0; sel = 3'b001;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        seen = 0;
        repeat (2) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
        end
        out_ready = 1'b0;
        checkOutput("abort_no_valid", 32'(seen), 32'd0);
    endtask

    // Test sequence
    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        logic [2:0]  rs;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 32'h0; b = 32'h0; cin = 1'b0; sel = 3'b000;
        #3;
        checkResult("reset", mk(32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);

        applyStimulus(32'hFFFF_FFFF, 32'h1, 1'b0, 3'b001, 0,
                      mk(32'h0, 1'b1, 1'b0, 1'b1, 1'b0), 1'b1);
        applyStimulus(32'h8000_0000, 32'h1, 1'b1, 3'b010, 1,
                      mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
        applyStimulus(32'h0, 32'h1234_5678, 1'b0, 3'b011, 0,
                      mk(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        applyStimulus(32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1, 3'b101, 5,
                      mk(32'h0, 1'b0, 1'b0, 1'b1, 1'b1), 1'b0);
        applyStimulus(32'h7FFF_FFFF, 32'h0, 1'b1, 3'b000, 0,
                      mk(32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0);

        rst_in_done();
        rst_in_busy();
        applyStimulus(32'h0000_00FF, 32'h1, 1'b0, 3'b001, 0,
                      mk(32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);

        for (int i = 0; i < 30; i++) begin
            ra = pick_operand();
            rb = pick_operand();
            rc = 1'($urandom);
            rs = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            applyStimulus(ra, rb, rc, rs, int'($urandom_range(0, 2)), model(ra, rb, rc, rs), 1'b0);
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/arith_unit_serial.md
ARITH_UNIT_SERIAL -- requirements
Module: arith_unit_serial

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; SHALL be >= 2.
REQ-002 Parameter DIGIT, default 8, bits processed per cycle; SHALL divide WIDTH exactly.
REQ-003 Port clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port in_valid  input  1  operand set present.
REQ-006 Port in_ready  output  1  unit accepts an operand set.
REQ-007 Port a  input  WIDTH  operand A.
REQ-008 Port b  input  WIDTH  operand B.
REQ-009 Port cin  input  1  carry-in.
REQ-010 Port sel  input  3  operation select.
REQ-011 Port out_valid  output  1  result present.
REQ-012 Port out_ready  input  1  consumer takes result.
REQ-013 Port out  output  WIDTH  result.
REQ-014 Ports cout, ovf, zero, err  output  1 each  carry-out, signed overflow, result-is-zero, illegal select.

Function
REQ-015 Operations SHALL be: sel=000 out=A+cin (transfer/increment); 001 A+B+cin (add); 010 A+~B+cin (subtract when cin=1); 011 A+{WIDTH{1}}+cin (decrement when cin=0).
REQ-016 sel=1xx SHALL be illegal: result delivered with normal latency and handshake, out=0, cout=0, ovf=0, zero=1, err=1.
REQ-017 Arithmetic SHALL be modulo 2^WIDTH; cout = carry out of bit WIDTH-1; ovf = carry into bit WIDTH-1 XOR cout; zero = (out==0); err=0 for legal selects.
REQ-018 FSM states: IDLE, BUSY, DONE; rst forces IDLE.
REQ-019 in_ready SHALL be 1 only in IDLE with rst low; out_valid SHALL be 1 only in DONE.
REQ-020 IDLE: on in_valid&&in_ready, capture a, b, cin, sel; clear chunk counter; go BUSY. in_valid without in_ready SHALL be ignored, nothing captured.
REQ-021 BUSY: each cycle process bits [k*DIGIT +: DIGIT] for chunk k, starting at k=0 (LSB chunk); carry held in a register between chunks, initialised from captured cin.
REQ-022 BUSY: after chunk N-1, N=WIDTH/DIGIT, register out, cout, ovf, zero, err and go DONE; accept at edge t SHALL give out_valid=1 after edge t+N.
REQ-023 DONE: out, cout, ovf, zero, err SHALL hold stable until out_valid&&out_ready, then go IDLE; no new operand accepted in BUSY or DONE.
REQ-024 Operand inputs SHALL be don't-care outside the accepting cycle; changes during BUSY SHALL not affect the result.
REQ-025 DIGIT=WIDTH SHALL give N=1 (single-cycle compute, one-cycle BUSY).

Reset
REQ-026 Asserting rst SHALL immediately (no clock) set state IDLE, out=0, cout=0, ovf=0, zero=0, err=0, out_valid=0, carry and counter cleared.
REQ-027 rst during BUSY or DONE SHALL abort the operation; its result is never presented.
REQ-028 First accept after rst deassertion SHALL be possible at the first rising clk edge with rst low.

Verification (WIDTH=32, DIGIT=8, N=4)
REQ-029 Assert rst mid-cycle -> same cycle out=0, all flags 0, out_valid=0; after release in_ready=1.
REQ-030 sel=001 a=0xFFFFFFFF b=0x00000001 cin=0 -> out_valid exactly 4 edges after accept, out=0x00000000, cout=1, ovf=0, zero=1, err=0.
REQ-031 sel=010 a=0x80000000 b=0x00000001 cin=1 -> out=0x7FFFFFFF, cout=1, ovf=1, zero=0.
REQ-032 sel=011 a=0x00000000 cin=0 -> out=0xFFFFFFFF, cout=0, ovf=0; sel=101 any operands -> out=0, err=1, zero=1.
REQ-033 Hold out_ready=0 5 cycles in DONE with in_valid=1 -> out/flags stable, in_ready=0, no capture; out_ready=1 -> IDLE next edge.
REQ-034 Assert rst at second BUSY cycle -> out_valid never rises for that operation; fresh operand after release completes correctly.
